// File: rtl/servo_pwm_tick.sv
// Purpose: free-running timebase (n_clk/tick) plus N_CH frame-aligned hobby-servo PWM outputs.
// Latency: a code latched at frame start shows on angle one clk after that edge; n_clk/tick are registered.
// Backpressure: none; all counters free-run and value is sampled only at frame start, so no flow control exists.
//
// Ports:
//   clk    - system clock, all state on the rising edge
//   reset  - asynchronous active-low reset
//   value  - packed 3-bit angle codes, channel i = value[3i+2:3i]
//   angle  - registered PWM output, bit i serves channel i
//   n_clk  - square wave toggling every SEC_CYCLES clocks
//   tick   - one-cycle strobe coincident with each n_clk toggle
module servo_pwm_tick #(
  parameter int N_CH          = 5,
  parameter int PERIOD_CYCLES = 1_000_000,
  parameter int STEP_CYCLES   = 25_000,
  parameter int SEC_CYCLES    = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3*N_CH-1:0] value,
  output logic [N_CH-1:0]   angle,
  output logic              n_clk,
  output logic              tick
);

  // Counter widths; guarded so a limit of 1 still yields a legal 1-bit counter.
  localparam int FW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int SW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  // Width registers must hold 5*STEP_CYCLES exactly, hence the +1.
  localparam int WW = $clog2(5 * STEP_CYCLES + 1);
  // Comparison width covers both operands so a width larger than the frame
  // (misparameterisation) compares correctly and simply holds the output high.
  localparam int CW = (FW > WW) ? FW : WW;

  localparam logic [FW-1:0] F_LAST = FW'(PERIOD_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SEC_CYCLES - 1);

  // Angle code to pulse width in clk cycles; 0, 6 and 7 switch the channel off.
  function automatic logic [WW-1:0] decode_width(input logic [2:0] code);
    logic [WW-1:0] w;
    w = '0;
    case (code)
      3'd1:    w = WW'(1 * STEP_CYCLES);
      3'd2:    w = WW'(2 * STEP_CYCLES);
      3'd3:    w = WW'(3 * STEP_CYCLES);
      3'd4:    w = WW'(4 * STEP_CYCLES);
      3'd5:    w = WW'(5 * STEP_CYCLES);
      default: w = '0;
    endcase
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame counter
  // ---------------------------------------------------------------------------
  logic [FW-1:0] fcnt;
  logic          frame_start;

  assign frame_start = (fcnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcnt <= '0;
    end else if (fcnt == F_LAST) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel width latch and PWM compare
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0][WW-1:0] width_q;
  logic [N_CH-1:0][WW-1:0] width_eff;
  logic [N_CH-1:0]         angle_nxt;

  // Widths only move at frame start, so a mid-frame code change can never
  // truncate or stretch a pulse already in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      width_q <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < N_CH; i++) begin
        width_q[i] <= decode_width(value[3*i +: 3]);
      end
    end
  end

  // On the frame-start edge the freshly decoded width is used directly, so the
  // pulse begins the cycle after the latching edge rather than one frame late.
  always_comb begin
    width_eff = width_q;
    angle_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (frame_start) begin
        width_eff[i] = decode_width(value[3*i +: 3]);
      end
      angle_nxt[i] = (CW'(fcnt) < CW'(width_eff[i]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      angle <= '0;
    end else begin
      angle <= angle_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Second timebase
  // ---------------------------------------------------------------------------
  logic [SW-1:0] scnt;
  logic          sec_wrap;

  assign sec_wrap = (scnt == S_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt  <= '0;
      n_clk <= 1'b0;
      tick  <= 1'b0;
    end else begin
      scnt  <= sec_wrap ? '0 : scnt + SW'(1);
      n_clk <= n_clk ^ sec_wrap;
      tick  <= sec_wrap;
    end
  end

endmodule

// File: tb/tb_servo_pwm_tick.sv
module tb_servo_pwm_tick;

  localparam int N_CH   = 5;
  localparam int PERIOD = 100;
  localparam int STEP   = 5;
  localparam int SEC    = 20;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [3*N_CH-1:0] value = '0;
  logic [N_CH-1:0]   angle;
  logic              n_clk;
  logic              tick;

  int checks = 0;
  int errors = 0;

  // Reference model state: rising edges seen since reset release, and a
  // scoreboard of expected per-channel widths, N_CH entries per frame.
  int k_ref = 0;
  int exp_q[$];

  // Monitor accumulators.
  int cnt[N_CH];
  bit seen_low[N_CH];
  bit shape_bad[N_CH];
  int mon_s;
  int mon_p;
  int mon_w;

  servo_pwm_tick #(
    .N_CH          (N_CH),
    .PERIOD_CYCLES (PERIOD),
    .STEP_CYCLES   (STEP),
    .SEC_CYCLES    (SEC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .angle (angle),
    .n_clk (n_clk),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  function automatic int ref_width(input int code);
    return (code >= 1 && code <= 5) ? code * STEP : 0;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: every frame start (every PERIOD edges after release) the codes
  // present on value define that frame's pulse widths.
  always @(posedge clk) begin
    if (!reset) begin
      k_ref = 0;
      exp_q.delete();
    end else begin
      if (k_ref % PERIOD == 0) begin
        for (int i = 0; i < N_CH; i++) begin
          exp_q.push_back(ref_width(int'(value[3*i +: 3])));
        end
      end
      k_ref++;
    end
  end

  // Monitor: samples on the falling edge, measures each channel's pulse per
  // frame and pops the expected widths when a frame completes.
  always @(negedge clk) begin
    if (!reset || k_ref == 0) begin
      check("reset angle", int'(angle), 0);
      check("reset n_clk", int'(n_clk), 0);
      check("reset tick", int'(tick), 0);
    end else begin
      mon_s = k_ref - 1;
      mon_p = mon_s % PERIOD;
      check("n_clk", int'(n_clk), ((mon_s + 1) / SEC) % 2);
      check("tick", int'(tick), ((mon_s + 1) % SEC == 0) ? 1 : 0);
      if (mon_p == 0) begin
        for (int i = 0; i < N_CH; i++) begin
          cnt[i]       = 0;
          seen_low[i]  = 1'b0;
          shape_bad[i] = 1'b0;
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (angle[i]) begin
          if (seen_low[i]) shape_bad[i] = 1'b1;
          cnt[i]++;
        end else begin
          seen_low[i] = 1'b1;
        end
      end
      if (mon_p == PERIOD - 1) begin
        if (exp_q.size() < N_CH) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: %0d entries queued, expected %0d", exp_q.size(), N_CH);
        end else begin
          for (int i = 0; i < N_CH; i++) begin
            mon_w = exp_q.pop_front();
            check($sformatf("ch%0d width", i), cnt[i], mon_w);
            check($sformatf("ch%0d shape", i), int'(shape_bad[i]), 0);
          end
        end
      end
    end
  end

  task automatic set_code(input int ch, input int code);
    logic [2:0] c;
    c = code[2:0];
    value[3*ch +: 3] = c;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Returns just after the negedge where the DUT frame counter holds p,
  // so a value change here is seen by the edge processing counter p.
  task automatic wait_pos(input int p);
    do @(negedge clk); while (k_ref % PERIOD != p);
    #2;
  endtask

  initial begin
    // Reset held with all codes at 3: outputs must stay low.
    #1;
    reset = 1'b0;
    for (int i = 0; i < N_CH; i++) set_code(i, 3);
    cycles(3);

    // Fixed codes 1..5 across three frames.
    for (int i = 0; i < N_CH; i++) set_code(i, i + 1);
    reset = 1'b1;
    cycles(3 * PERIOD);

    // Mid-frame changes: ch0 3->5 after its pulse, ch1 4->1 during its pulse.
    wait_pos(50);
    set_code(0, 3);
    set_code(1, 4);
    wait_pos(10);
    set_code(1, 1);
    wait_pos(40);
    set_code(0, 5);
    cycles(2 * PERIOD);

    // Off and invalid codes for three full frames.
    wait_pos(60);
    set_code(1, 0);
    set_code(2, 6);
    set_code(3, 7);
    cycles(3 * PERIOD + 50);

    // Random code changes at random points in the frame.
    for (int r = 0; r < 40; r++) begin
      cycles(int'($urandom_range(1, 40)));
      set_code(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 7)));
    end
    cycles(PERIOD);

    // Asynchronous reset during an active pulse on ch4.
    wait_pos(60);
    set_code(4, 5);
    wait_pos(8);
    check("pre-reset ch4", int'(angle[4]), 1);
    reset = 1'b0;
    #1;
    check("async angle", int'(angle), 0);
    check("async n_clk", int'(n_clk), 0);
    check("async tick", int'(tick), 0);
    cycles(2);
    reset = 1'b1;
    cycles(2 * PERIOD + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_tick.md
Name: servo_pwm_tick

Overview:
- Combined timing block for the arm controller.
- Generates a slow toggling timebase `n_clk`, nominally 1 s per edge, which paces the servo sequencing state machine.
- Generates N_CH independent hobby-servo PWM outputs, each driven from a 3-bit angle code.
- Sits between the servo/gripper sequencer (supplies angle codes) and the servo output pins.

Parameters:
- N_CH, 5: number of PWM channels (2 arm servos + 3 grippers).
- PERIOD_CYCLES, 1_000_000: PWM frame length in clk cycles (20 ms at 50 MHz).
- STEP_CYCLES, 25_000: pulse-width increment per angle code step (0.5 ms at 50 MHz).
- SEC_CYCLES, 50_000_000: clk cycles between `n_clk` toggles (1 s at 50 MHz).

Ports:
- clk, input, 1: system clock; all state on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- value, input, 3*N_CH: packed angle codes; channel i = value[3i+2:3i].
- angle, output, N_CH: PWM output per channel; bit i serves channel i.
- n_clk, output, 1: timebase square wave; toggles every SEC_CYCLES cycles.
- tick, output, 1: one-cycle strobe, high on the cycle `n_clk` toggles.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - frame counter = 0, second counter = 0;
  - all latched widths = 0;
  - angle = 0, n_clk = 0, tick = 0.
- Angle code decode, width W in cycles:
  - 0 → 0 (output held low, channel off);
  - 1 → 1*STEP (0°); 2 → 2*STEP (45°); 3 → 3*STEP (90°); 4 → 4*STEP (135°); 5 → 5*STEP (180°);
  - 6, 7 → 0 (invalid, treated as off).
- Frame counter:
  - counts 0..PERIOD_CYCLES-1, incrementing every clk, wrapping to 0;
  - first value after reset release is 0.
- Width latch: per-channel W is captured from `value` on the edge where the frame counter is 0. Changes to `value` mid-frame take effect only at the next frame start; no glitches or truncated pulses.
- angle[i] is registered:
  - high for exactly W_i consecutive cycles starting the cycle after the frame counter reads 0;
  - low for the remaining PERIOD_CYCLES-W_i cycles.
- Latency: `value` applied before frame start → pulse visible 1 cycle after the latching edge.
- W = 0 → angle[i] stays 0 for the whole frame.
- W ≥ PERIOD_CYCLES (misparameterisation) → output high the whole frame; the design must not wrap or overflow.
- Counter widths = $clog2 of the respective limit; width arithmetic must not truncate 5*STEP_CYCLES.
- Second counter:
  - counts 0..SEC_CYCLES-1 and wraps;
  - on the wrap edge, n_clk inverts and tick=1 for that one cycle; tick=0 otherwise.
  - First n_clk rise occurs SEC_CYCLES cycles after reset release.
- Frame and second counters are independent; channels are independent of each other.
- Reset asserted mid-frame: outputs drop low immediately (asynchronous). After release, a fresh frame starts at counter 0 and latches the current `value`.

Test Plan (override N_CH=5, PERIOD_CYCLES=100, STEP_CYCLES=5, SEC_CYCLES=20):
- Reset check: hold reset=0 for 3 cycles with value all 3s → angle=0, n_clk=0, tick=0 throughout.
- Fixed codes: release reset with codes ch0..ch4 = 1,2,3,4,5 → high widths 5,10,15,20,25 cycles in every 100-cycle frame.
- Mid-frame change: ch0 code 3→5 at cycle 40 of a frame → current pulse stays 15 cycles; next frame's pulse is 25 cycles.
- Off/invalid codes: codes 0, 6, 7 → angle bit low across 3 full frames.
- Timebase: after reset release → n_clk toggles at cycles 20, 40, 60; tick is a single-cycle pulse at each toggle; period 40.
- Async reset: assert reset=0 at frame cycle 7 with ch4=5 → angle[4] falls without waiting for a clock edge. After release, a full 25-cycle pulse is produced from a new frame start.
